// File: rtl/siso_shift_register_if.sv
// Serial bit-stream link: the producer drives s_in, the shift register returns s_out.
// The master side drives s_in and observes s_out. The slave side is the delay line.
interface siso_shift_register_if;
    logic s_in;
    logic s_out;

    modport master (
        output s_in,
        input  s_out
    );

    modport slave (
        input  s_in,
        output s_out
    );
endinterface

// File: rtl/siso_shift_register.sv
// Purpose: serial-in/serial-out delay line, async active-low clear empties every stage.
// Latency: DEPTH clk cycles from the s_in sample to s_out.
// Backpressure: none; the register shifts on every rising edge while clear is high.
module siso_shift_register #(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  clear,
    siso_shift_register_if.slave  ser
);

    generate
        if (DEPTH < 1 || DEPTH > 64) begin : g_bad_depth
            $error("siso_shift_register: DEPTH must be within 1..64");
        end
    endgenerate

    logic [DEPTH-1:0] stage;

    // Stage 0 takes the new bit. Every later stage copies its neighbour, so DEPTH=1 collapses to a single D flop.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            stage <= '0;
        end else begin
            stage[0] <= ser.s_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign ser.s_out = stage[DEPTH-1];

endmodule

// File: tb/tb_siso_shift_register.sv
// Directed bench for siso_shift_register at DEPTH 4, 1 and 8 sharing one clock, clear and serial input.
// The DEPTH=4 instance carries the directed vectors; all three are checked against a delay model on a random stream.
module tb_siso_shift_register;

    logic clk;
    logic clear;
    logic s_in;
    logic clk_run;

    int total;
    int passed;

    logic h[$];

    siso_shift_register_if if4 ();
    siso_shift_register_if if1 ();
    siso_shift_register_if if8 ();

    assign if4.s_in = s_in;
    assign if1.s_in = s_in;
    assign if8.s_in = s_in;

    siso_shift_register #(.DEPTH(4)) dut4 (.clk(clk), .clear(clear), .ser(if4.slave));
    siso_shift_register #(.DEPTH(1)) dut1 (.clk(clk), .clear(clear), .ser(if1.slave));
    siso_shift_register #(.DEPTH(8)) dut8 (.clk(clk), .clear(clear), .ser(if8.slave));

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000 ns");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    function automatic logic model_out(input int d);
        int n;
        n = h.size();
        return (n >= d) ? h[n-d] : 1'b0;
    endfunction

    // Values driven before edges 1..9 after release, and the DEPTH=4 output after each of those edges.
    logic pat_in  [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic pat_exp [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic lat_exp [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        total   = 0;
        passed  = 0;
        clear   = 1'b0;
        s_in    = 1'b0;
        clk_run = 1'b1;

        #2;
        check("reset_out_d4", {7'd0, if4.s_out}, 8'd0);
        check("reset_out_d1", {7'd0, if1.s_out}, 8'd0);
        check("reset_out_d8", {7'd0, if8.s_out}, 8'd0);

        // Held clear ignores edges even with s_in high.
        s_in = 1'b1;
        for (int e = 0; e < 3; e++) begin
            edge_sample();
            check($sformatf("clear_held_out_e%0d", e), {7'd0, if4.s_out}, 8'd0);
        end
        check("clear_held_stage_d4", {4'd0, dut4.stage}, 8'd0);
        check("clear_held_stage_d8", dut8.stage, 8'd0);

        // Pattern 1011 followed by constant 1.
        @(negedge clk);
        clear = 1'b1;
        s_in  = pat_in[0];
        for (int k = 0; k < 9; k++) begin
            edge_sample();
            check($sformatf("pattern_e%0d", k + 1), {7'd0, if4.s_out}, {7'd0, pat_exp[k]});
            if (k < 8) s_in = pat_in[k+1];
        end
        check("pattern_full_stage", {4'd0, dut4.stage}, 8'h0f);

        // Mid-stream clear for half a cycle.
        clear = 1'b0;
        s_in  = 1'b0;
        #1;
        check("midclear_out_now", {7'd0, if4.s_out}, 8'd0);
        check("midclear_stage_now", {4'd0, dut4.stage}, 8'd0);
        @(negedge clk);
        clear = 1'b1;
        for (int e = 0; e < 4; e++) begin
            edge_sample();
            check($sformatf("midclear_after_e%0d", e + 1), {7'd0, if4.s_out}, 8'd0);
        end

        // Single-bit pulse: DEPTH=4 shows it after the 4th edge counting the sampling edge.
        s_in = 1'b1;
        for (int j = 0; j < 6; j++) begin
            edge_sample();
            s_in = 1'b0;
            check($sformatf("pulse_j%0d", j), {7'd0, if4.s_out}, {7'd0, lat_exp[j]});
        end

        // Load ones, stop the clock while high, then clear asynchronously.
        s_in = 1'b1;
        for (int e = 0; e < 4; e++) edge_sample();
        check("load_ones_d4", {7'd0, if4.s_out}, 8'd1);
        check("load_ones_d1", {7'd0, if1.s_out}, 8'd1);
        clk_run = 1'b0;
        #3;
        clear = 1'b0;
        #1;
        check("async_clk_still_high", {7'd0, clk}, 8'd1);
        check("async_out_d4", {7'd0, if4.s_out}, 8'd0);
        check("async_out_d1", {7'd0, if1.s_out}, 8'd0);
        check("async_out_d8", {7'd0, if8.s_out}, 8'd0);
        check("async_stage_d4", {4'd0, dut4.stage}, 8'd0);
        check("async_stage_d8", dut8.stage, 8'd0);
        #1;
        clear = 1'b1;
        h.delete();
        clk_run = 1'b1;

        // Random 64-bit stream against the delay model for all three depths.
        s_in = 1'($urandom_range(0, 1));
        for (int n = 0; n < 64; n++) begin
            @(posedge clk);
            h.push_back(s_in);
            #1;
            check($sformatf("rand_d4_n%0d", n), {7'd0, if4.s_out}, {7'd0, model_out(4)});
            check($sformatf("rand_d1_n%0d", n), {7'd0, if1.s_out}, {7'd0, model_out(1)});
            check($sformatf("rand_d8_n%0d", n), {7'd0, if8.s_out}, {7'd0, model_out(8)});
            s_in = 1'($urandom_range(0, 1));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
